// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the program-ROM access arbiter.
package rom_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] TEXT_BASE_DEF = 32'h0040_0000;
  localparam int unsigned       ROM_BYTES_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Transaction latched at arbitration time.
  typedef struct packed {
    owner_e            owner;
    logic [ADDR_W-1:0] off;
    logic              err;
  } xact_t;

endpackage

// File: rtl/rom_addr_xlate.sv
// Virtual address to ROM byte offset translation with alignment/range check.
module rom_addr_xlate
  import rom_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TEXT_BASE = TEXT_BASE_DEF,
  parameter int unsigned       ROM_BYTES = ROM_BYTES_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] off,
  output logic              err
);

  // Addresses below the text segment pass through untranslated.
  always_comb begin
    off = (addr >= TEXT_BASE) ? (addr - TEXT_BASE) : addr;
    err = (addr[1:0] != 2'b00) || (off >= ADDR_W'(ROM_BYTES));
  end

endmodule

// File: rtl/rom_access_arbiter.sv
// Two-port (fetch/data) arbiter in front of the combinational program ROM.
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TEXT_BASE      = TEXT_BASE_DEF,
  parameter int unsigned       ROM_BYTES      = ROM_BYTES_DEF,
  parameter int unsigned       FETCH_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_rvalid,
  output logic              f_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q
);

  state_e            state_q, state_d;
  xact_t             xact_q, xact_d;
  owner_e            last_owner_q, last_owner_d;
  logic              f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
  logic              f_rvalid_q, f_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic              f_err_q, f_err_d, d_err_q, d_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic              arb_f;
  logic [ADDR_W-1:0] arb_addr;
  logic [ADDR_W-1:0] x_off;
  logic              x_err;
  logic [DATA_W-1:0] acc_data;

  // Winner select: F wins unless D is alone, or round-robin says it is D's turn.
  always_comb begin
    arb_f    = f_req && (!d_req || (FETCH_PRIORITY != 0) || (last_owner_q == OWN_D));
    arb_addr = arb_f ? f_addr : d_addr;
  end

  rom_addr_xlate #(
    .TEXT_BASE (TEXT_BASE),
    .ROM_BYTES (ROM_BYTES)
  ) u_xlate (
    .addr (arb_addr),
    .off  (x_off),
    .err  (x_err)
  );

  // Errored accesses read back as a NOP word.
  always_comb begin
    acc_data = xact_q.err ? '0 : rom_q;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    xact_d       = xact_q;
    last_owner_d = last_owner_q;
    f_gnt_d      = 1'b0;
    d_gnt_d      = 1'b0;
    f_rvalid_d   = 1'b0;
    d_rvalid_d   = 1'b0;
    f_err_d      = 1'b0;
    d_err_d      = 1'b0;
    f_rdata_d    = f_rdata_q;
    d_rdata_d    = d_rdata_q;
    rom_addr_d   = '0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (f_req || d_req) begin
          state_d      = ST_ACCESS;
          xact_d.owner = arb_f ? OWN_F : OWN_D;
          xact_d.off   = x_off;
          xact_d.err   = x_err;
          f_gnt_d      = arb_f;
          d_gnt_d      = !arb_f;
          rom_addr_d   = x_err ? '0 : x_off;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        last_owner_d = xact_q.owner;
        if (xact_q.owner == OWN_F) begin
          f_rdata_d  = acc_data;
          f_rvalid_d = 1'b1;
          f_err_d    = xact_q.err;
        end else begin
          d_rdata_d  = acc_data;
          d_rvalid_d = 1'b1;
          d_err_d    = xact_q.err;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      xact_q       <= '0;
      last_owner_q <= OWN_D;
      f_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      f_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      f_err_q      <= 1'b0;
      d_err_q      <= 1'b0;
      f_rdata_q    <= '0;
      d_rdata_q    <= '0;
      rom_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      xact_q       <= xact_d;
      last_owner_q <= last_owner_d;
      f_gnt_q      <= f_gnt_d;
      d_gnt_q      <= d_gnt_d;
      f_rvalid_q   <= f_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      f_err_q      <= f_err_d;
      d_err_q      <= d_err_d;
      f_rdata_q    <= f_rdata_d;
      d_rdata_q    <= d_rdata_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

  assign f_gnt    = f_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign f_rvalid = f_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign f_err    = f_err_q;
  assign d_err    = d_err_q;
  assign f_rdata  = f_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign rom_addr = rom_addr_q;

endmodule
